// File: rtl/des_block_sequencer_if.sv
// rtl/des_block_sequencer_if.sv - RAM and DES-core bus between the block sequencer and its memories/core
interface des_block_sequencer_if #(
  parameter int ADDR_W = 9
) ();
  logic [ADDR_W-1:0] ram_i_addr;
  logic [31:0]       ram_i_dout;
  logic [ADDR_W-1:0] ram_o_addr;
  logic [31:0]       ram_o_din;
  logic              ram_o_write;
  logic [63:0]       des_in;
  logic              des_decrypt;
  logic [3:0]        des_round_sel;
  logic [63:0]       des_out;

  modport master (
    output ram_i_addr, ram_o_addr, ram_o_din, ram_o_write,
    output des_in, des_decrypt, des_round_sel,
    input  ram_i_dout, des_out
  );

  modport slave (
    input  ram_i_addr, ram_o_addr, ram_o_din, ram_o_write,
    input  des_in, des_decrypt, des_round_sel,
    output ram_i_dout, des_out
  );
endinterface

// File: rtl/des_block_sequencer.sv
// rtl/des_block_sequencer.sv - ECB/CBC sequencer feeding 64-bit blocks from RAM through an iterative DES core
module des_block_sequencer #(
  parameter int ADDR_W = 9
) (
  input  logic                  clk1,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  decrypt,
  input  logic                  cbc_en,
  input  logic [63:0]           iv,
  input  logic [ADDR_W-1:0]     block_count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     blocks_done,
  des_block_sequencer_if.master bus
);
  localparam logic [ADDR_W-1:0] MAX_BLOCKS = {1'b1, {(ADDR_W-1){1'b0}}};

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD0, S_LOAD1, S_LOAD2, S_ROUND, S_SAVE0, S_SAVE1, S_NEXT, S_DONE
  } state_t;

  state_t            state_q;
  logic              dec_q, cbc_q, busy_q, done_q, ram_o_write_q;
  logic [63:0]       chain_q, blk_q, res_q, des_in_q;
  logic [31:0]       lo_q, ram_o_din_q;
  logic [ADDR_W-1:0] n_q, k_q, blocks_done_q, ram_i_addr_q, ram_o_addr_q;
  logic [3:0]        round_q;

  logic [ADDR_W-1:0] n_d, k_d, addr_lo, addr_hi, addr_next;
  logic [63:0]       blk_d, res_d;

  always_comb begin
    n_d       = (block_count > MAX_BLOCKS) ? MAX_BLOCKS : block_count;
    k_d       = k_q + 1'b1;
    addr_lo   = {k_q[ADDR_W-2:0], 1'b0};
    addr_hi   = {k_q[ADDR_W-2:0], 1'b1};
    addr_next = {k_d[ADDR_W-2:0], 1'b0};
    blk_d     = {bus.ram_i_dout, lo_q};
    res_d     = (dec_q && cbc_q) ? (bus.des_out ^ chain_q) : bus.des_out;
  end

  // Outputs are registered one state early so each state presents its own address/data.
  always_ff @(posedge clk1) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      dec_q         <= 1'b0;
      cbc_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ram_o_write_q <= 1'b0;
      chain_q       <= '0;
      blk_q         <= '0;
      res_q         <= '0;
      des_in_q      <= '0;
      lo_q          <= '0;
      ram_o_din_q   <= '0;
      n_q           <= '0;
      k_q           <= '0;
      blocks_done_q <= '0;
      ram_i_addr_q  <= '0;
      ram_o_addr_q  <= '0;
      round_q       <= '0;
    end else begin
      done_q        <= 1'b0;
      ram_o_write_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          dec_q         <= decrypt;
          cbc_q         <= cbc_en;
          chain_q       <= iv;
          n_q           <= n_d;
          k_q           <= '0;
          blocks_done_q <= '0;
          busy_q        <= 1'b1;
          ram_i_addr_q  <= '0;
          state_q       <= (n_d == '0) ? S_DONE : S_LOAD0;
        end
        S_LOAD0: begin
          ram_i_addr_q <= addr_hi;
          state_q      <= S_LOAD1;
        end
        S_LOAD1: begin
          lo_q    <= bus.ram_i_dout;
          state_q <= S_LOAD2;
        end
        S_LOAD2: begin
          blk_q    <= blk_d;
          des_in_q <= (cbc_q && !dec_q) ? (blk_d ^ chain_q) : blk_d;
          round_q  <= '0;
          state_q  <= S_ROUND;
        end
        S_ROUND: if (round_q == 4'd15) begin
          res_q         <= res_d;
          round_q       <= '0;
          ram_o_addr_q  <= addr_lo;
          ram_o_din_q   <= res_d[31:0];
          ram_o_write_q <= 1'b1;
          state_q       <= S_SAVE0;
        end else begin
          round_q <= round_q + 4'd1;
        end
        S_SAVE0: begin
          ram_o_addr_q  <= addr_hi;
          ram_o_din_q   <= res_q[63:32];
          ram_o_write_q <= 1'b1;
          state_q       <= S_SAVE1;
        end
        S_SAVE1: state_q <= S_NEXT;
        S_NEXT: begin
          chain_q       <= dec_q ? blk_q : res_q;
          blocks_done_q <= blocks_done_q + 1'b1;
          if (k_d == n_q) begin
            state_q <= S_DONE;
          end else begin
            k_q          <= k_d;
            ram_i_addr_q <= addr_next;
            state_q      <= S_LOAD0;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign blocks_done       = blocks_done_q;
  assign bus.ram_i_addr    = ram_i_addr_q;
  assign bus.ram_o_addr    = ram_o_addr_q;
  assign bus.ram_o_din     = ram_o_din_q;
  assign bus.ram_o_write   = ram_o_write_q;
  assign bus.des_in        = des_in_q;
  assign bus.des_decrypt   = dec_q;
  assign bus.des_round_sel = round_q;
endmodule

// File: tb/tb_des_block_sequencer.sv
// tb/tb_des_block_sequencer.sv - directed bench for des_block_sequencer with RAM models and a stand-in core
module tb_des_block_sequencer;
  localparam logic [63:0] CORE_KEY = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] IV_A     = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] IV_B     = 64'hA5A5_0F0F_3C3C_9696;

  logic       clk1 = 1'b0;
  logic       reset_n, start, decrypt, cbc_en, busy, done, clr_o;
  logic [63:0] iv;
  logic [8:0] block_count, blocks_done;

  logic [31:0] mem_i [512];
  logic [31:0] mem_o [512];
  logic [31:0] exp_o [512];
  logic [31:0] plain [512];
  int          wr_count = 0;
  logic [8:0]  last_wr_addr = '0;
  int          checks = 0;
  int          errors = 0;

  des_block_sequencer_if #(.ADDR_W(9)) bus ();

  des_block_sequencer #(.ADDR_W(9)) dut (
    .clk1(clk1), .reset_n(reset_n), .start(start), .decrypt(decrypt), .cbc_en(cbc_en),
    .iv(iv), .block_count(block_count), .busy(busy), .done(done),
    .blocks_done(blocks_done), .bus(bus)
  );

  always #5 clk1 = ~clk1;

  // Stand-in core: invertible byte rotate plus xor; only trustworthy on the last round.
  function automatic logic [63:0] fcore(input logic [63:0] x, input logic dec);
    logic [63:0] y;
    if (!dec) begin
      fcore = {x[55:0], x[63:56]} ^ CORE_KEY;
    end else begin
      y = x ^ CORE_KEY;
      fcore = {y[7:0], y[63:8]};
    end
  endfunction

  assign bus.des_out = (bus.des_round_sel == 4'd15) ? fcore(bus.des_in, bus.des_decrypt)
                                                    : 64'hDEAD_BEEF_DEAD_BEEF;

  always @(posedge clk1) bus.ram_i_dout <= mem_i[bus.ram_i_addr];

  always @(posedge clk1) begin
    if (clr_o) begin
      for (int i = 0; i < 512; i++) mem_o[i] <= '0;
    end else if (bus.ram_o_write) begin
      mem_o[bus.ram_o_addr] <= bus.ram_o_din;
    end
  end

  always @(posedge clk1) begin
    if (bus.ram_o_write) begin
      wr_count     <= wr_count + 1;
      last_wr_addr <= bus.ram_o_addr;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_out();
    @(negedge clk1) clr_o = 1'b1;
    @(negedge clk1) clr_o = 1'b0;
  endtask

  task automatic fill_pattern(input int nwords, input logic [7:0] seed);
    for (int i = 0; i < nwords; i++) begin
      mem_i[i] = {seed, 24'(i)} ^ (32'(i) * 32'h9E37_79B9);
      plain[i] = mem_i[i];
    end
  endtask

  task automatic build_expected(input logic dec, input logic cbc, input logic [63:0] ivv, input int nblk);
    logic [63:0] chain, b, r;
    chain = ivv;
    for (int k = 0; k < nblk; k++) begin
      b = {mem_i[2*k+1], mem_i[2*k]};
      if (!dec) begin
        r = fcore(cbc ? (b ^ chain) : b, 1'b0);
        chain = r;
      end else begin
        r = fcore(b, 1'b1) ^ (cbc ? chain : 64'd0);
        chain = b;
      end
      exp_o[2*k]   = r[31:0];
      exp_o[2*k+1] = r[63:32];
    end
  endtask

  task automatic check_buf(input string tag, input int nwords);
    int bad;
    bad = 0;
    for (int i = 0; i < nwords; i++) if (mem_o[i] !== exp_o[i]) bad++;
    check(tag, bad, 0);
  endtask

  task automatic run_job(input logic dec, input logic cbc, input logic [63:0] ivv, input logic [8:0] cnt,
                         input int exp_cycles, input string tag, input bit disturb);
    int n;
    bit seen;
    decrypt = dec; cbc_en = cbc; iv = ivv; block_count = cnt;
    @(negedge clk1) start = 1'b1;
    @(negedge clk1) start = 1'b0;
    n = 1;
    seen = 1'b0;
    while (!seen && n < 8000) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (disturb && n == 10) begin
          start = 1'b1; decrypt = ~dec; cbc_en = ~cbc; iv = ~ivv; block_count = 9'd7;
        end else if (disturb && n == 11) begin
          start = 1'b0;
        end
        @(negedge clk1);
        n++;
      end
    end
    check({tag, "_done_seen"}, 64'(seen), 1);
    check({tag, "_latency"}, n, exp_cycles);
    decrypt = dec; cbc_en = cbc; iv = ivv; block_count = cnt;
    @(negedge clk1);
    check({tag, "_done_pulse"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int snap;
    bit found;
    reset_n = 1'b0; start = 1'b0; decrypt = 1'b0; cbc_en = 1'b0; clr_o = 1'b0;
    iv = '0; block_count = '0;
    repeat (3) @(negedge clk1);
    check("rst_ctrl", {busy, done, bus.ram_o_write, bus.des_decrypt}, 4'b0000);
    check("rst_blocks_done", blocks_done, 0);
    check("rst_addrs", {bus.ram_i_addr, bus.ram_o_addr}, 0);
    check("rst_des_in", bus.des_in, 0);
    check("rst_round_sel", bus.des_round_sel, 0);
    reset_n = 1'b1;

    // ECB encrypt: 0123456789ABCDEF -> rotl8 ^ key = 23456789_543210FE
    mem_i[0] = 32'h89AB_CDEF; mem_i[1] = 32'h0123_4567;
    clear_out();
    snap = wr_count;
    run_job(1'b0, 1'b0, 64'd0, 9'd1, 24, "ecb_enc", 1'b0);
    check("ecb_enc_w0", mem_o[0], 32'h5432_10FE);
    check("ecb_enc_w1", mem_o[1], 32'h2345_6789);
    check("ecb_enc_blocks", blocks_done, 1);
    check("ecb_enc_writes", wr_count - snap, 2);

    mem_i[0] = mem_o[0]; mem_i[1] = mem_o[1];
    clear_out();
    run_job(1'b1, 1'b0, 64'd0, 9'd1, 24, "ecb_dec", 1'b0);
    check("ecb_dec_w0", mem_o[0], 32'h89AB_CDEF);
    check("ecb_dec_w1", mem_o[1], 32'h0123_4567);
    check("ecb_dec_blocks", blocks_done, 1);

    // CBC round trip over four blocks
    fill_pattern(8, 8'h3C);
    build_expected(1'b0, 1'b1, IV_A, 4);
    clear_out();
    run_job(1'b0, 1'b1, IV_A, 9'd4, 90, "cbc_enc", 1'b0);
    check_buf("cbc_enc_data", 8);
    check("cbc_enc_blocks", blocks_done, 4);
    for (int i = 0; i < 8; i++) begin
      mem_i[i] = mem_o[i];
      exp_o[i] = plain[i];
    end
    clear_out();
    run_job(1'b1, 1'b1, IV_A, 9'd4, 90, "cbc_dec", 1'b0);
    check_buf("cbc_dec_roundtrip", 8);

    clear_out();
    snap = wr_count;
    run_job(1'b0, 1'b0, 64'd0, 9'd0, 2, "n0", 1'b0);
    check("n0_writes", wr_count - snap, 0);
    check("n0_blocks", blocks_done, 0);

    fill_pattern(512, 8'h5A);
    build_expected(1'b0, 1'b0, 64'd0, 256);
    clear_out();
    snap = wr_count;
    run_job(1'b0, 1'b0, 64'd0, 9'd300, 22 * 256 + 2, "n300", 1'b0);
    check("n300_writes", wr_count - snap, 512);
    check("n300_last_addr", last_wr_addr, 511);
    check("n300_blocks", blocks_done, 256);
    check_buf("n300_data", 512);

    fill_pattern(6, 8'hC3);
    build_expected(1'b0, 1'b1, IV_B, 3);
    clear_out();
    run_job(1'b0, 1'b1, IV_B, 9'd3, 68, "disturb", 1'b1);
    check_buf("disturb_data", 6);
    check("disturb_blocks", blocks_done, 3);

    // Abort in the middle of block 2's rounds
    fill_pattern(8, 8'h77);
    build_expected(1'b0, 1'b1, IV_A, 4);
    clear_out();
    decrypt = 1'b0; cbc_en = 1'b1; iv = IV_A; block_count = 9'd4;
    @(negedge clk1) start = 1'b1;
    @(negedge clk1) start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (blocks_done == 9'd2 && bus.des_round_sel == 4'd5) found = 1'b1;
      else @(negedge clk1);
    end
    check("abort_reached", 64'(found), 1);
    reset_n = 1'b0;
    @(negedge clk1);
    reset_n = 1'b1;
    check("abort_ctrl", {busy, done, bus.ram_o_write, bus.des_decrypt}, 4'b0000);
    check("abort_outs", {blocks_done, bus.ram_i_addr, bus.ram_o_addr, bus.des_round_sel}, 0);
    check("abort_des_in", bus.des_in, 0);
    snap = wr_count;
    repeat (60) @(negedge clk1);
    check("abort_no_writes", wr_count - snap, 0);
    check("abort_idle", {busy, done}, 2'b00);
    check_buf("abort_partial", 4);

    mem_i[0] = 32'h89AB_CDEF; mem_i[1] = 32'h0123_4567;
    clear_out();
    run_job(1'b0, 1'b0, 64'd0, 9'd1, 24, "post_abort", 1'b0);
    check("post_abort_w0", mem_o[0], 32'h5432_10FE);
    check("post_abort_w1", mem_o[1], 32'h2345_6789);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
